// File: rtl/tone_seq_pkg.sv
// Shared types for the tone sequencer: FSM state encoding, note table entry layout
// and default field widths.
package tone_seq_pkg;

    localparam int DIV_W_DEF = 14;
    localparam int DUR_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_FIN
    } state_e;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] div;
        logic [DUR_W_DEF-1:0] dur;
    } note_t;

    // Prescaler width; a one-cycle tick still needs a 1-bit counter.
    function automatic int pre_width(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

endpackage

// File: rtl/tone_div.sv
// Programmable half-period divider: the tone toggles every div+1 enabled cycles;
// div=0 is a rest and holds the tone low.
module tone_div #(
    parameter int DIV_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tone
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (clr || (en && (div == '0))) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (en) begin
            // >= rather than == so a count left above a new, smaller div still wraps
            if (cnt_q >= div) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/tone_seq_ctrl.sv
// Note-table tone sequencer with start/stop/busy/done handshake.
// Define TONE_SEQ_LOOP_EN to add a loop input that restarts the table instead of finishing.
module tone_seq_ctrl
    import tone_seq_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DIV_W-1:0]           wr_div,
    input  logic [DUR_W-1:0]           wr_dur,
    input  logic [$clog2(DEPTH):0]     len,
`ifdef TONE_SEQ_LOOP_EN
    input  logic                       loop,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   note_idx,
    output logic                       tone_out
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PRE_W = pre_width(TICK_DIV);

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [DUR_W-1:0] dur;
    } entry_t;

    entry_t tbl [DEPTH];

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic   tick;
    logic   last_note;
    logic   loop_on;
    entry_t rd_entry;

`ifdef TONE_SEQ_LOOP_EN
    assign loop_on = loop;
`else
    assign loop_on = 1'b0;
`endif

    // Table storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            tbl[wr_addr] <= '{div: wr_div, dur: wr_dur};
        end
    end

    assign rd_entry  = tbl[idx_q];
    assign tick      = (pre_q == PRE_W'(TICK_DIV - 1));
    assign last_note = ({1'b0, idx_q} == (len_q - 1'b1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        div_d   = div_q;
        dur_d   = dur_q;
        pre_d   = pre_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start && !stop) begin
                    len_d = len;
                    if (len == '0) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    div_d   = rd_entry.div;
                    dur_d   = (rd_entry.dur == '0) ? DUR_W'(1) : rd_entry.dur;
                    pre_d   = '0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    pre_d = tick ? '0 : pre_q + 1'b1;
                    if (tick) begin
                        dur_d = dur_q - 1'b1;
                        if (dur_q == DUR_W'(1)) begin
                            if (!last_note) begin
                                idx_d   = idx_q + 1'b1;
                                state_d = S_LOAD;
                            end else if (loop_on) begin
                                idx_d   = '0;
                                state_d = S_LOAD;
                            end else begin
                                state_d = S_FIN;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            div_q   <= '0;
            dur_q   <= '0;
            pre_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            div_q   <= div_d;
            dur_q   <= dur_d;
            pre_q   <= pre_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Divider runs only across PLAY->PLAY edges and is cleared whenever PLAY is left or entered.
    tone_div #(
        .DIV_W (DIV_W)
    ) u_tone_div (
        .clk   (clk),
        .rst_n (en),
        .en    (state_q == S_PLAY),
        .clr   (state_d != S_PLAY),
        .div   (div_q),
        .tone  (tone_out)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = idx_q;

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// Directed bench for tone_seq_ctrl with a 4-cycle duration tick; covers playback,
// rests, stop, async reset, write blocking and (with TONE_SEQ_LOOP_EN) looping.
module tb_tone_seq_ctrl;
    import tone_seq_pkg::*;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        en;
    logic        start, stop, wr_en;
    logic [2:0]  wr_addr;
    logic [13:0] wr_div;
    logic [7:0]  wr_dur;
    logic [3:0]  len;
    logic        loop;
    logic        busy, done, tone_out;
    logic [2:0]  note_idx;

    note_t model_tbl [8];
    int    n_assert = 0;
    int    n_fail   = 0;
    logic [127:0] tr_a, tr_b, tr_c;

    always #5 clk = ~clk;

    tone_seq_ctrl #(
        .DIV_W    (14),
        .DUR_W    (8),
        .DEPTH    (8),
        .TICK_DIV (TICK)
    ) dut (
        .clk      (clk),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_div   (wr_div),
        .wr_dur   (wr_dur),
        .len      (len),
`ifdef TONE_SEQ_LOOP_EN
        .loop     (loop),
`endif
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx),
        .tone_out (tone_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input int addr, input int dv, input int du);
        wr_en   = 1'b1;
        wr_addr = addr[2:0];
        wr_div  = dv[13:0];
        wr_dur  = du[7:0];
        step();
        wr_en = 1'b0;
        model_tbl[addr] = '{div: dv[13:0], dur: du[7:0]};
    endtask

    // Plays n notes from the model table, checking every cycle; optionally holds start
    // and hammers table writes during playback, and records the tone trace.
    task automatic play(input int n, input bit hold_start, input bit wr_during,
                        output logic [127:0] tr);
        int   d, dv, k, pos;
        logic exp_tone;
        tr  = '0;
        pos = 0;
        start = 1'b1;
        len   = n[3:0];
        step();
        if (!hold_start) start = 1'b0;
        if (wr_during) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_div = 14'd7; wr_dur = 8'd1;
        end
        for (int i = 0; i < n; i++) begin
            d  = (model_tbl[i].dur == 0) ? 1 : int'(model_tbl[i].dur);
            dv = int'(model_tbl[i].div);
            for (int c = 0; c <= d * TICK; c++) begin
                k = c - 1;
                exp_tone = (c == 0 || dv == 0) ? 1'b0 : logic'((k / (dv + 1)) % 2);
                chk($sformatf("note_idx n%0d c%0d", i, c), note_idx, i);
                chk($sformatf("busy n%0d c%0d", i, c), busy, 1);
                chk($sformatf("tone n%0d c%0d", i, c), tone_out, exp_tone);
                chk($sformatf("done_early n%0d c%0d", i, c), done, 0);
                tr[pos] = tone_out;
                pos++;
                if (i == n - 1 && c == d * TICK) begin
                    start = 1'b0;
                    wr_en = 1'b0;
                end
                step();
            end
        end
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 1);
        step();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_idx", note_idx, 0);
        $display("play len=%0d hold_start=%0b wr_during=%0b cycles=%0d", n, hold_start, wr_during, pos);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_div = '0; wr_dur = '0; len = '0; loop = 1'b0;
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", note_idx, 0);
        chk("rst_tone", tone_out, 0);
        en = 1'b1;
        step();

        // Single note, half period 3 cycles, 12 PLAY cycles.
        write_entry(0, 2, 3);
        play(1, 1'b0, 1'b0, tr_a);

        // start held and writes attempted during playback: no restart, no table change.
        play(1, 1'b1, 1'b1, tr_b);
        chk("held_start_trace", tr_b[31:0], tr_a[31:0]);
        play(1, 1'b0, 1'b0, tr_c);
        chk("replay_trace", tr_c[31:0], tr_a[31:0]);

        // Three notes including a rest.
        write_entry(0, 5, 1);
        write_entry(1, 0, 2);
        write_entry(2, 1, 1);
        play(3, 1'b0, 1'b0, tr_b);

        // len=0: immediate done, never busy.
        start = 1'b1; len = 4'd0;
        step();
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        step();
        chk("len0_done_off", done, 0);
        chk("len0_busy_off", busy, 0);
        $display("len0 start done pulse checked");

        // start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1; len = 4'd1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        step();
        chk("startstop_busy2", busy, 0);
        $display("start+stop in idle checked");

        // stop at the second tick of a dur=5 note.
        write_entry(0, 3, 5);
        start = 1'b1; len = 4'd1;
        step();
        start = 1'b0;
        repeat (8) step();
        chk("stop_pre_tone", tone_out, 1);
        chk("stop_pre_busy", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_tone", tone_out, 0);
        chk("stop_idx", note_idx, 0);
        chk("stop_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stop_after_done%0d", i), done, 0);
            chk($sformatf("stop_after_busy%0d", i), busy, 0);
        end
        $display("stop mid note checked");

        // Async reset during the second note.
        write_entry(1, 3, 5);
        start = 1'b1; len = 4'd2;
        step();
        start = 1'b0;
        repeat (21 + 6) step();
        chk("rstmid_pre_idx", note_idx, 1);
        chk("rstmid_pre_tone", tone_out, 1);
        chk("rstmid_pre_busy", busy, 1);
        #2;
        en = 1'b0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_tone", tone_out, 0);
        chk("rstmid_idx", note_idx, 0);
        chk("rstmid_done", done, 0);
        step();
        en = 1'b1;
        step();
        chk("rstmid_after_busy", busy, 0);
        $display("async reset mid play checked");

`ifdef TONE_SEQ_LOOP_EN
        write_entry(0, 1, 1);
        write_entry(1, 2, 1);
        loop = 1'b1; start = 1'b1; len = 4'd2;
        step();
        start = 1'b0;
        for (int c = 0; c < 4 * (1 + TICK); c++) begin
            chk($sformatf("loop_idx c%0d", c), note_idx, (c / (1 + TICK)) % 2);
            chk($sformatf("loop_done c%0d", c), done, 0);
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0; loop = 1'b0;
        chk("loop_stop_busy", busy, 0);
        chk("loop_stop_idx", note_idx, 0);
        $display("loop playback checked");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
